// File: rtl/barker_pkg.sv
// rtl/barker_pkg.sv - shared Barker code constants and sizing helper
//   BARKER_11, BARKER_13 : reference codes, MSB is the first chip on the wire
//   score_width(len)     : bits needed to hold a match count of 0..len
package barker_pkg;

  localparam logic [10:0] BARKER_11 = 11'b11100010010;
  localparam logic [12:0] BARKER_13 = 13'b1111100110101;

  function automatic int score_width(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/barker_popcount.sv
// rtl/barker_popcount.sv - combinational population count
//   bits : W-bit input vector
//   ones : number of set bits in bits, 0..W
module barker_popcount #(
  parameter int W = 11
) (
  input  logic [W-1:0]             bits,
  output logic [$clog2(W+1)-1:0]   ones
);

  localparam int OW = $clog2(W + 1);

  always_comb begin
    ones = '0;
    for (int i = 0; i < W; i++) begin
      ones = ones + OW'(bits[i]);
    end
  end

endmodule

// File: rtl/barker_stream_correlator.sv
// rtl/barker_stream_correlator.sv - sliding-window code correlator on a chip stream
//   i_clk, i_rst                       : clock, synchronous active-high reset
//   s_tdata/s_tvalid/s_tlast/s_tready  : input chip stream
//   m_tdata                            : match count of the window ending at this chip
//   m_tuser                            : [0] positive hit, [1] inverted hit
//   m_tlast/m_tvalid/m_tready          : output beat framing and handshake
//   o_hit_count                        : saturating count of delivered positive hits
module barker_stream_correlator
  import barker_pkg::*;
#(
  parameter int                  CODE_LEN   = 11,
  parameter logic [CODE_LEN-1:0] CODE       = BARKER_11,
  parameter int                  THRESHOLD  = CODE_LEN,
  parameter bit                  INV_DETECT = 1'b1,
  parameter int                  SCORE_W    = score_width(CODE_LEN)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               s_tdata,
  input  logic               s_tvalid,
  input  logic               s_tlast,
  output logic               s_tready,
  output logic [SCORE_W-1:0] m_tdata,
  output logic [1:0]         m_tuser,
  output logic               m_tlast,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic [15:0]        o_hit_count
);

  if (CODE_LEN < 2 || CODE_LEN > 64) begin : g_bad_code_len
    $error("barker_stream_correlator: CODE_LEN %0d outside 2..64", CODE_LEN);
  end
  if (THRESHOLD < 1 || THRESHOLD > CODE_LEN) begin : g_bad_threshold
    $error("barker_stream_correlator: THRESHOLD %0d outside 1..CODE_LEN", THRESHOLD);
  end

  localparam logic [SCORE_W-1:0] LEN_S = SCORE_W'(CODE_LEN);
  localparam logic [SCORE_W-1:0] THR_S = SCORE_W'(THRESHOLD);
  localparam logic [SCORE_W-1:0] INV_S = SCORE_W'(CODE_LEN - THRESHOLD);

  logic                adv;
  logic                accept;
  // The oldest chip falls out of the window on every shift, so only the
  // newest CODE_LEN-1 chips need to be kept between beats.
  logic [CODE_LEN-2:0] hist;
  logic [CODE_LEN-1:0] window_next;
  logic [SCORE_W-1:0]  fill;
  logic [SCORE_W-1:0]  fill_next;

  logic                s1_valid;
  logic                s1_last;
  logic                s1_full;
  logic [CODE_LEN-1:0] s1_window;

  logic [SCORE_W-1:0]  mismatches;
  logic [SCORE_W-1:0]  score;
  logic                hit_pos;
  logic                hit_inv;

  // Both stages move together whenever the output register can be emptied.
  assign adv         = ~m_tvalid | m_tready;
  assign s_tready    = adv & ~i_rst;
  assign accept      = s_tvalid & s_tready;
  assign window_next = {hist, s_tdata};
  assign fill_next   = (fill == LEN_S) ? LEN_S : fill + SCORE_W'(1);

  // Window and fill only change on an accepting edge, so a stalled tlast
  // beat cannot clear the frame early.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hist <= '0;
      fill <= '0;
    end else if (accept) begin
      if (s_tlast) begin
        hist <= '0;
        fill <= '0;
      end else begin
        hist <= window_next[CODE_LEN-2:0];
        fill <= fill_next;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_full   <= 1'b0;
      s1_window <= '0;
    end else if (adv) begin
      s1_valid <= accept;
      if (accept) begin
        s1_window <= window_next;
        s1_last   <= s_tlast;
        s1_full   <= (fill_next == LEN_S);
      end
    end
  end

  barker_popcount #(
    .W (CODE_LEN)
  ) u_popcount (
    .bits (s1_window ^ CODE),
    .ones (mismatches)
  );

  assign score   = LEN_S - mismatches;
  assign hit_pos = s1_full & (score >= THR_S);
  assign hit_inv = s1_full & INV_DETECT & (score <= INV_S);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tuser  <= 2'b00;
      m_tlast  <= 1'b0;
    end else if (adv) begin
      m_tvalid <= s1_valid;
      if (s1_valid) begin
        m_tdata <= score;
        m_tuser <= {hit_inv, hit_pos};
        m_tlast <= s1_last;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_hit_count <= '0;
    end else if (m_tvalid & m_tready & m_tuser[0] & (o_hit_count != 16'hFFFF)) begin
      o_hit_count <= o_hit_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_barker_stream_correlator.sv
// tb/tb_barker_stream_correlator.sv - randomized and directed check of barker_stream_correlator
module tb_barker_stream_correlator;

  localparam int L = 11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_tdata = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        m_tready = 1'b0;

  logic        s_tready_a, m_tlast_a, m_tvalid_a;
  logic [3:0]  m_tdata_a;
  logic [1:0]  m_tuser_a;
  logic [15:0] hit_a;
  logic        s_tready_b, m_tlast_b, m_tvalid_b;
  logic [3:0]  m_tdata_b;
  logic [1:0]  m_tuser_b;
  logic [15:0] hit_b;

  always #5 clk = ~clk;

  // a: exact match only, inverted detection on
  barker_stream_correlator u_dut_a (
    .i_clk (clk), .i_rst (rst),
    .s_tdata (s_tdata), .s_tvalid (s_tvalid), .s_tlast (s_tlast), .s_tready (s_tready_a),
    .m_tdata (m_tdata_a), .m_tuser (m_tuser_a), .m_tlast (m_tlast_a),
    .m_tvalid (m_tvalid_a), .m_tready (m_tready), .o_hit_count (hit_a)
  );

  // b: one chip error tolerated, inverted detection off
  barker_stream_correlator #(
    .THRESHOLD (10), .INV_DETECT (1'b0)
  ) u_dut_b (
    .i_clk (clk), .i_rst (rst),
    .s_tdata (s_tdata), .s_tvalid (s_tvalid), .s_tlast (s_tlast), .s_tready (s_tready_b),
    .m_tdata (m_tdata_b), .m_tuser (m_tuser_b), .m_tlast (m_tlast_b),
    .m_tvalid (m_tvalid_b), .m_tready (m_tready), .o_hit_count (hit_b)
  );

  typedef struct {
    int       data;
    logic [1:0] ua;
    logic [1:0] ub;
    logic     last;
    int       acc;
  } exp_t;

  logic [10:0] code_v = 11'b11100010010;
  exp_t        expq[$];
  bit          chips[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          hit_exp_a = 0;
  int          hit_exp_b = 0;
  bit          lat_chk = 1'b0;
  bit          prev_stall = 1'b0;
  logic [3:0]  prev_data;
  logic [1:0]  prev_user;
  logic        prev_last;
  int          last_data;
  logic [1:0]  last_ua, last_ub;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: chips of the current frame, newest last; the window is the
  // newest L chips with missing older positions read as 0.
  function automatic exp_t model_beat(input bit d, input bit l);
    exp_t e;
    int   n, score;
    bit   w, full;
    chips.push_back(d);
    if (chips.size() > L) void'(chips.pop_front());
    n = chips.size();
    score = 0;
    for (int k = 0; k < L; k++) begin
      w = (k < n) ? chips[n-1-k] : 1'b0;
      if (w == code_v[k]) score++;
    end
    full   = (n == L);
    e.data = score;
    e.ua   = {full && (score <= 0), full && (score >= 11)};
    e.ub   = {1'b0, full && (score >= 10)};
    e.last = l;
    e.acc  = cyc;
    if (l) chips.delete();
    return e;
  endfunction

  task automatic step(input bit v, input bit d, input bit l, input bit rdy, input bit r,
                      output bit acc);
    exp_t e;
    @(negedge clk);
    s_tvalid = v; s_tdata = d; s_tlast = l; m_tready = rdy; rst = r;
    #1;
    cyc++;
    acc = 1'b0;
    if (r) begin
      expq.delete();
      chips.delete();
      hit_exp_a = 0;
      hit_exp_b = 0;
      prev_stall = 1'b0;
    end else begin
      check("hit_count_a", hit_a, hit_exp_a);
      check("hit_count_b", hit_b, hit_exp_b);
      check("s_tready", s_tready_a, !m_tvalid_a || rdy);
      if (prev_stall) begin
        check("stall_valid", m_tvalid_a, 1);
        check("stall_data", m_tdata_a, prev_data);
        check("stall_user", m_tuser_a, prev_user);
        check("stall_last", m_tlast_a, prev_last);
      end
      if (v && s_tready_a) begin
        acc = 1'b1;
        expq.push_back(model_beat(d, l));
      end
      if (m_tvalid_a && rdy) begin
        if (expq.size() == 0) begin
          check("spurious_beat", 1, 0);
        end else begin
          e = expq.pop_front();
          check("score_a", m_tdata_a, e.data);
          check("user_a", m_tuser_a, e.ua);
          check("last_a", m_tlast_a, e.last);
          check("valid_b", m_tvalid_b, 1);
          check("score_b", m_tdata_b, e.data);
          check("user_b", m_tuser_b, e.ub);
          if (lat_chk) check("latency", cyc - e.acc, 2);
          if (e.ua[0]) hit_exp_a++;
          if (e.ub[0]) hit_exp_b++;
          last_data = m_tdata_a;
          last_ua   = m_tuser_a;
          last_ub   = m_tuser_b;
        end
      end
      prev_stall = m_tvalid_a && !rdy;
      prev_data  = m_tdata_a;
      prev_user  = m_tuser_a;
      prev_last  = m_tlast_a;
    end
  endtask

  task automatic tick(input bit v, input bit d, input bit l, input bit rdy, input bit r);
    bit dummy;
    step(v, d, l, rdy, r, dummy);
  endtask

  task automatic send_word(input logic [10:0] p, input bit last_at_end);
    for (int i = 10; i >= 0; i--) tick(1'b1, p[i], last_at_end && (i == 0), 1'b1, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && expq.size() != 0; i++) tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("drain_empty", expq.size(), 0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    bit         acc, chip, tl;
    int         accepted, iters, pat_idx;
    bit         pat_inv;

    // reset state
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_s_tready", s_tready_a, 0);
    check("rst_m_tvalid", m_tvalid_a, 0);
    check("rst_m_tdata", m_tdata_a, 0);
    check("rst_m_tuser", m_tuser_a, 0);
    check("rst_m_tlast", m_tlast_a, 0);
    check("rst_hit_count", hit_a, 0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("post_rst_s_tready", s_tready_a, 1);

    // exact code
    lat_chk = 1'b1;
    send_word(code_v, 1'b1);
    drain();
    check("t1_score", last_data, 11);
    check("t1_user", last_ua, 2'b01);
    check("t1_hits", hit_a, 1);

    // inverted code
    send_word(~code_v, 1'b1);
    drain();
    check("t2_score", last_data, 0);
    check("t2_user_a", last_ua, 2'b10);
    check("t2_user_b", last_ub, 2'b00);
    check("t2_hits", hit_a, 1);

    // single flipped chip
    send_word(code_v ^ 11'b00000100000, 1'b1);
    drain();
    check("t3_score", last_data, 10);
    check("t3_user_a", last_ua, 2'b00);
    check("t3_user_b", last_ub, 2'b01);
    check("t3_hits_b", hit_b, 2);

    // short frame ending on chip 5, then a full code
    for (int i = 0; i < 5; i++) tick(1'b1, 1'($urandom % 2), i == 4, 1'b1, 1'b0);
    send_word(code_v, 1'b1);
    drain();
    check("t4_score", last_data, 11);
    check("t4_user", last_ua, 2'b01);
    check("t4_hits", hit_a, 2);
    lat_chk = 1'b0;

    // random traffic with backpressure and bubbles
    accepted = 0;
    iters = 0;
    pat_idx = L;
    pat_inv = 1'b0;
    while (accepted < 1000 && iters < 6000) begin
      chip = (pat_idx < L) ? (code_v[L-1-pat_idx] ^ pat_inv) : 1'($urandom % 2);
      tl = ($urandom % 24) == 0;
      step(($urandom % 10) < 7, chip, tl, ($urandom % 10) < 7, 1'b0, acc);
      iters++;
      if (acc) begin
        accepted++;
        if (pat_idx < L) pat_idx++;
        else if ($urandom % 12 == 0) begin
          pat_idx = 0;
          pat_inv = 1'($urandom % 2);
        end
      end
    end
    check("rand_budget", accepted, 1000);
    drain();

    // reset in the middle of a code
    lat_chk = 1'b1;
    for (int i = 10; i > 5; i--) tick(1'b1, code_v[i], 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send_word(code_v, 1'b1);
    drain();
    check("t6_score", last_data, 11);
    check("t6_hits_a", hit_a, 1);
    check("t6_hits_b", hit_b, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
